// File: rtl/key_cmd_queue_if.sv
// Key-to-command queue bus: key pulses and flow control in, head command and status out.
// The master modport is the queue itself; the slave modport is the key/consumer side.
interface key_cmd_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          game_en;
   logic          key_left;
   logic          key_right;
   logic          key_rotate;
   logic          key_down;
   logic          key_drop;
   logic          cmd_ready;
   logic          ovf_clr;
   logic          cmd_valid;
   logic [2:0]    cmd_code;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   modport master (
      input  game_en, key_left, key_right, key_rotate, key_down, key_drop,
      input  cmd_ready, ovf_clr,
      output cmd_valid, cmd_code, fifo_count, overflow
   );

   modport slave (
      output game_en, key_left, key_right, key_rotate, key_down, key_drop,
      output cmd_ready, ovf_clr,
      input  cmd_valid, cmd_code, fifo_count, overflow
   );
endinterface

// File: rtl/key_cmd_queue.sv
// Collects single-cycle key pulses into per-key pending flags and feeds them, one per cycle
// and in fixed priority, into a first-word-fall-through command FIFO.
module key_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   key_cmd_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [2:0] CODE_LEFT   = 3'd0;
   localparam logic [2:0] CODE_RIGHT  = 3'd1;
   localparam logic [2:0] CODE_ROTATE = 3'd2;
   localparam logic [2:0] CODE_DOWN   = 3'd3;
   localparam logic [2:0] CODE_DROP   = 3'd4;

   logic [4:0]    key_vec;
   logic [4:0]    pend_q, pend_d;
   logic [4:0]    xfer;
   logic [2:0]    push_code;
   logic          push, pop, merge, wr_en;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [2:0]    mem_q [DEPTH];

   // Bit position of each pending flag equals its command code.
   assign key_vec = {bus.key_drop, bus.key_down, bus.key_rotate, bus.key_right, bus.key_left};
   assign pop     = (count_q != '0) && bus.cmd_ready;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      push_code = CODE_LEFT;
      if (pend_q[CODE_DROP])        push_code = CODE_DROP;
      else if (pend_q[CODE_ROTATE]) push_code = CODE_ROTATE;
      else if (pend_q[CODE_LEFT])   push_code = CODE_LEFT;
      else if (pend_q[CODE_RIGHT])  push_code = CODE_RIGHT;
      else if (pend_q[CODE_DOWN])   push_code = CODE_DOWN;
   end

   always_comb begin
      push    = (pend_q != '0) && ((count_q != FULL) || pop);
      xfer    = push ? (5'd1 << push_code) : 5'd0;
      merge   = |(key_vec & pend_q & ~xfer);
      wr_en   = push && bus.game_en;
      pend_d  = (pend_q & ~xfer) | key_vec;
      rd_d    = rd_q + PW'(pop);
      wr_d    = wr_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
      // A merged pulse must win over a same-cycle clear.
      ovf_d   = merge || (ovf_q && !bus.ovf_clr);
      if (!bus.game_en) begin
         pend_d  = '0;
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
         ovf_d   = ovf_q && !bus.ovf_clr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: the storage array is not reset; count_q gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem_q[wr_q] <= push_code;
   end

   assign bus.cmd_valid  = (count_q != '0);
   assign bus.cmd_code   = bus.cmd_valid ? mem_q[rd_q] : CODE_LEFT;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_key_cmd_queue.sv
// Self-checking bench: a cycle model with an expected-command queue checked every cycle,
// plus directed checks of latency, priority order, merging, flush and reset behaviour.
module tb_key_cmd_queue;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   int       mq[$];
   int       got[$];
   bit [4:0] mpend;
   bit       movf;

   key_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

   key_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
   endtask

   task automatic clear_keys();
      bus.key_left   = 1'b0;
      bus.key_right  = 1'b0;
      bus.key_rotate = 1'b0;
      bus.key_down   = 1'b0;
      bus.key_drop   = 1'b0;
      bus.ovf_clr    = 1'b0;
   endtask

   // Advance one clock: update the model from the current inputs, then compare outputs.
   task automatic step();
      int       prio[5];
      int       pick;
      bit       pop, can, merge;
      bit [4:0] keys;
      bit [4:0] np;
      prio = '{4, 2, 0, 1, 3};
      keys = {bus.key_drop, bus.key_down, bus.key_rotate, bus.key_right, bus.key_left};
      pop  = (mq.size() != 0) && bus.cmd_ready;
      if (rst) begin
         mq.delete();
         mpend = '0;
         movf  = 1'b0;
      end else if (!bus.game_en) begin
         mq.delete();
         mpend = '0;
         if (bus.ovf_clr) movf = 1'b0;
      end else begin
         pick = -1;
         foreach (prio[i]) if (pick < 0 && mpend[prio[i]]) pick = prio[i];
         can = (pick >= 0) && ((mq.size() < DEPTH) || pop);
         if (pop) begin
            check("pop_code", int'(bus.cmd_code), mq[0]);
            got.push_back(int'(bus.cmd_code));
            void'(mq.pop_front());
         end
         merge = 1'b0;
         for (int k = 0; k < 5; k++)
            if (keys[k] && mpend[k] && !(can && k == pick)) merge = 1'b1;
         np = mpend;
         if (can) begin
            np[pick] = 1'b0;
            mq.push_back(pick);
         end
         mpend = np | keys;
         movf  = merge ? 1'b1 : (bus.ovf_clr ? 1'b0 : movf);
      end
      @(posedge clk);
      #1;
      check("valid", int'(bus.cmd_valid), int'(mq.size() != 0));
      check("count", int'(bus.fifo_count), mq.size());
      check("ovf", int'(bus.overflow), int'(movf));
      if (mq.size() != 0) check("head", int'(bus.cmd_code), mq[0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_got(input string tag, input int exp[$]);
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
      got.delete();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      mpend   = '0;
      movf    = 1'b0;
      rst     = 1'b1;
      bus.game_en   = 1'b1;
      bus.cmd_ready = 1'b0;
      clear_keys();
      idle(2);
      check("rst_valid", int'(bus.cmd_valid), 0);
      check("rst_code", int'(bus.cmd_code), 0);
      check("rst_count", int'(bus.fifo_count), 0);
      check("rst_ovf", int'(bus.overflow), 0);
      rst = 1'b0;
      idle(3);

      // Single rotate pulse: visible two cycles later and held until popped.
      bus.key_rotate = 1'b1; step(); clear_keys();
      check("lat_t1_valid", int'(bus.cmd_valid), 0);
      step();
      check("lat_t2_valid", int'(bus.cmd_valid), 1);
      check("lat_t2_code", int'(bus.cmd_code), 2);
      check("lat_t2_count", int'(bus.fifo_count), 1);
      idle(3);
      check("lat_hold_code", int'(bus.cmd_code), 2);
      bus.cmd_ready = 1'b1; step(); bus.cmd_ready = 1'b0;
      check("lat_popped", int'(bus.fifo_count), 0);
      got.delete();

      // All five keys at once: priority order, down left pending then delivered fifth.
      {bus.key_left, bus.key_right, bus.key_rotate, bus.key_down, bus.key_drop} = 5'b11111;
      step(); clear_keys();
      idle(6);
      check("all5_count", int'(bus.fifo_count), 4);
      check("all5_head", int'(bus.cmd_code), 4);
      bus.cmd_ready = 1'b1; step();
      check("all5_full_pop_count", int'(bus.fifo_count), 4);
      idle(5); bus.cmd_ready = 1'b0;
      check("all5_empty", int'(bus.fifo_count), 0);
      check("all5_ovf", int'(bus.overflow), 0);
      check_got("all5_order", '{4, 2, 0, 1, 3});

      // Full FIFO, left pending, second left pulse merges and flags overflow.
      {bus.key_right, bus.key_rotate, bus.key_down, bus.key_drop} = 4'b1111;
      step(); clear_keys();
      idle(6);
      check("merge_full", int'(bus.fifo_count), 4);
      bus.key_left = 1'b1; step(); step(); clear_keys();
      check("merge_ovf_set", int'(bus.overflow), 1);
      bus.ovf_clr = 1'b1; step(); clear_keys();
      check("merge_ovf_clr", int'(bus.overflow), 0);
      bus.cmd_ready = 1'b1; idle(8); bus.cmd_ready = 1'b0;
      check_got("merge_order", '{4, 2, 1, 3, 0});

      // Full FIFO with drop pending: a pop lets drop in at the tail in the same cycle.
      {bus.key_left, bus.key_right, bus.key_rotate, bus.key_down} = 4'b1111;
      step(); clear_keys();
      idle(6);
      bus.key_drop = 1'b1; step(); clear_keys();
      check("fullpop_pre", int'(bus.fifo_count), 4);
      bus.cmd_ready = 1'b1; step(); bus.cmd_ready = 1'b0;
      check("fullpop_count", int'(bus.fifo_count), 4);
      check("fullpop_head", int'(bus.cmd_code), 0);
      bus.cmd_ready = 1'b1; idle(6); bus.cmd_ready = 1'b0;
      check_got("fullpop_order", '{2, 0, 1, 3, 4});

      // Flush with game_en low while down is pulsed.
      {bus.key_left, bus.key_right, bus.key_down} = 3'b111;
      step(); clear_keys();
      idle(5);
      check("flush_pre", int'(bus.fifo_count), 3);
      bus.game_en = 1'b0; bus.key_down = 1'b1; step();
      bus.game_en = 1'b1; clear_keys();
      check("flush_count", int'(bus.fifo_count), 0);
      check("flush_valid", int'(bus.cmd_valid), 0);
      idle(4);
      check("flush_no_down", int'(bus.cmd_valid), 0);

      // Reset mid-operation with stored entries, a pending flag and overflow set.
      {bus.key_left, bus.key_right, bus.key_rotate} = 3'b111;
      step(); clear_keys();
      bus.key_right = 1'b1; step(); clear_keys();
      step();
      check("rstmid_pre_count", int'(bus.fifo_count), 2);
      check("rstmid_pre_ovf", int'(bus.overflow), 1);
      rst = 1'b1; bus.cmd_ready = 1'b1; bus.key_drop = 1'b1; step();
      rst = 1'b0; bus.cmd_ready = 1'b0; clear_keys();
      check("rstmid_valid", int'(bus.cmd_valid), 0);
      check("rstmid_code", int'(bus.cmd_code), 0);
      check("rstmid_count", int'(bus.fifo_count), 0);
      check("rstmid_ovf", int'(bus.overflow), 0);
      bus.key_right = 1'b1; step(); clear_keys();
      step();
      check("post_rst_valid", int'(bus.cmd_valid), 1);
      check("post_rst_code", int'(bus.cmd_code), 1);
      check("post_rst_count", int'(bus.fifo_count), 1);
      idle(3);
      check("post_rst_only_one", int'(bus.fifo_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/key_cmd_queue.md
KEY_CMD_QUEUE -- requirements
Module: key_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; SHALL be a power of 2, minimum 2.
REQ-002 Port: clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: game_en  input  1  high = accept keys; low = flush and ignore keys.
REQ-005 Port: key_left, key_right, key_rotate, key_down, key_drop  input  1 each  single-cycle key pulses from the per-key debouncers.
REQ-006 Port: cmd_ready  input  1  consumer (game control FSM) accepts head command.
REQ-007 Port: ovf_clr  input  1  clears the overflow flag.
REQ-008 Port: cmd_valid  output  1  head command present.
REQ-009 Port: cmd_code  output  3  head command: 0 left, 1 right, 2 rotate, 3 down, 4 drop; 5-7 never produced.
REQ-010 Port: fifo_count  output  clog2(DEPTH)+1  number of stored commands, 0..DEPTH.
REQ-011 Port: overflow  output  1  sticky lost-key indicator.

Function
REQ-012 Each key SHALL have a pending flag, set at the clock edge where its pulse is high and game_en=1.
REQ-013 Each cycle, at most one pending flag SHALL transfer into the FIFO, in priority drop > rotate > left > right > down.
REQ-014 A transfer SHALL occur when any flag is pending and (fifo_count<DEPTH, or fifo_count==DEPTH with a pop in the same cycle); the transferred flag SHALL clear at that edge.
REQ-015 A pulse for a key whose flag is pending and not being transferred that cycle SHALL be merged (no second entry) and SHALL set overflow.
REQ-016 A pulse arriving in the same cycle its flag transfers SHALL re-set the flag (new pending entry); no overflow.
REQ-017 Latency: pulse high in cycle t, FIFO empty, no higher-priority pending flag -> cmd_valid=1 with matching cmd_code in cycle t+2.
REQ-018 FIFO SHALL be first-word-fall-through; cmd_code SHALL be driven from a register/array, never combinationally from key inputs.
REQ-019 Pop SHALL occur at an edge where cmd_valid=1 and cmd_ready=1; cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-020 cmd_valid SHALL equal (fifo_count!=0).
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 Pending flags SHALL hold while the FIFO is full; no pending command SHALL be dropped except by REQ-015 merging, game_en=0 or rst.
REQ-023 game_en=0 at an edge SHALL clear all pending flags, empty the FIFO (fifo_count=0) and ignore all key pulses that cycle; overflow SHALL be unaffected.
REQ-024 ovf_clr=1 SHALL clear overflow at that edge; a simultaneous set SHALL win (overflow=1).
REQ-025 Commands SHALL be delivered in FIFO order; order among simultaneous pulses SHALL follow REQ-013.

Reset
REQ-026 rst=1 at an edge SHALL clear all pending flags, read/write pointers, fifo_count=0, cmd_valid=0, cmd_code=0, overflow=0.
REQ-027 rst SHALL take precedence over game_en, ovf_clr, key pulses and cmd_ready; reset mid-operation SHALL discard all stored and pending commands.
REQ-028 First cycle after rst deasserts SHALL accept key pulses normally.

Verification
REQ-029 Single key_rotate pulse in cycle 5, cmd_ready=0 -> cycle 7 cmd_valid=1, cmd_code=2, fifo_count=1; held until pop.
REQ-030 All five keys pulsed in cycle 5, cmd_ready=0, DEPTH=4 -> codes 4,2,0,1 queued, fifo_count=4, down flag pending; first pop then delivers 3 as fifth command; overflow=0.
REQ-031 FIFO full, key_left pending, second key_left pulse -> overflow=1, only one left command eventually delivered; ovf_clr -> overflow=0 next cycle.
REQ-032 FIFO full, cmd_ready=1 with pending key_drop -> fifo_count stays 4, drop written at tail, head advances.
REQ-033 3 entries queued, game_en=0 one cycle while key_down pulsed -> fifo_count=0, cmd_valid=0, no down command ever appears.
REQ-034 rst asserted with 2 entries and a pending flag -> next cycle all outputs at reset values; pulse right after release -> cmd_code=1 valid 2 cycles later.
